// File: rtl/ingress_frame_tagger.sv
// ingress_frame_tagger: per-port ingress buffer that filters frames, resolves the destination by MAC lookup and replays them to one crossbar lane.
// Optional INGRESS_LKP_TIMEOUT_EN: floods a frame (dest 4) when the lookup is not acked within P_LKP_TIMEOUT cycles.
module ingress_frame_tagger #(
    parameter int P_PORT           = 0,
    parameter int P_BUF_ADDR_WIDTH = 11,
    parameter int P_DESC_DEPTH     = 4,
    parameter int P_LKP_TIMEOUT    = 16
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic [7:0]  mac_data_i,
    input  logic        mac_valid_i,
    input  logic        mac_eof_i,
    input  logic        mac_err_i,
    output logic        lkp_req_o,
    output logic [47:0] lkp_mac_o,
    input  logic        lkp_ack_i,
    input  logic [2:0]  lkp_port_i,
    output logic [7:0]  rx_data_o,
    output logic        rx_done_o,
    output logic [2:0]  rx_dest_o,
    output logic [15:0] drop_cnt_o
);
    localparam int AW = P_BUF_ADDR_WIDTH;
    localparam int DW = $clog2(P_DESC_DEPTH);
    localparam logic [AW:0] CAP = {1'b1, {AW{1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_STREAM, S_DISCARD, S_GAP} state_t;

    typedef struct packed {
        logic [47:0]   dmac;
        logic [AW-1:0] start;
        logic [AW:0]   len;
    } desc_t;

    logic [7:0] mem [2**AW];
    desc_t      desc_mem [P_DESC_DEPTH];
    logic [7:0] ram_q;

    logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, len_q, len_d, frm_start_q, frm_start_d;
    logic          in_frm_q, in_frm_d, ovf_q, ovf_d;
    logic [47:0]   dmac_q, dmac_d;
    logic [DW:0]   dwp_q, dwp_d, drp_q, drp_d;
    state_t        state_q, state_d;
    logic [2:0]    dest_q, dest_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          lkp_req_q, lkp_req_d;
    logic [47:0]   lkp_mac_q, lkp_mac_d;
    logic          rv1_q, rv1_d, last1_q, last1_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_done_q, rx_done_d;
    logic [2:0]    rx_dest_q, rx_dest_d;
    logic [15:0]   drop_q, drop_d;

    logic [AW:0]   used, idx, start, new_len;
    logic [47:0]   dmac_n;
    logic          sof, ovf_n, we, eof, desc_full, desc_empty, accept, reject;
    logic          pop, disc, tmo_exp;
    logic [16:0]   drop_sum;
    desc_t         head;
    logic [AW-1:0] raddr;

`ifdef INGRESS_LKP_TIMEOUT_EN
    localparam int TW = $clog2(P_LKP_TIMEOUT + 1);
    logic [TW-1:0] tmo_q, tmo_d;

    always_comb begin
        tmo_d   = (state_q == S_LOOKUP) ? tmo_q + TW'(1) : '0;
        tmo_exp = (state_q == S_LOOKUP) && (tmo_q == TW'(P_LKP_TIMEOUT - 1));
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) tmo_q <= '0;
        else         tmo_q <= tmo_d;
    end
`else
    // A negative timeout is meaningless, so this is constant low in any sane build.
    assign tmo_exp = (P_LKP_TIMEOUT < 0);
`endif

    // Write side: the frame is committed to the descriptor FIFO only on a clean eof.
    always_comb begin
        used      = wr_ptr_q - rd_ptr_q;
        sof       = !in_frm_q;
        idx       = sof ? '0 : len_q;
        start     = sof ? wr_ptr_q : frm_start_q;
        ovf_n     = (!sof && ovf_q) || (used == CAP);
        we        = mac_valid_i && !ovf_n;
        new_len   = idx + (AW+1)'(we);
        dmac_n    = (idx < (AW+1)'(6)) ? {dmac_q[39:0], mac_data_i} : dmac_q;
        desc_full = (dwp_q[DW] != drp_q[DW]) && (dwp_q[DW-1:0] == drp_q[DW-1:0]);
        eof       = mac_valid_i && mac_eof_i;
        accept    = eof && !mac_err_i && !ovf_n && (new_len >= (AW+1)'(14)) && !desc_full;
        reject    = eof && !accept;
        wr_ptr_d    = wr_ptr_q;
        in_frm_d    = in_frm_q;
        frm_start_d = frm_start_q;
        len_d       = len_q;
        ovf_d       = ovf_q;
        dmac_d      = dmac_q;
        if (mac_valid_i) begin
            wr_ptr_d    = reject ? start : wr_ptr_q + (AW+1)'(we);
            in_frm_d    = !eof;
            frm_start_d = start;
            len_d       = new_len;
            ovf_d       = ovf_n;
            dmac_d      = dmac_n;
        end
        dwp_d = dwp_q + (DW+1)'(accept);
    end

    always_ff @(posedge clk_i) begin
        if (we) mem[wr_ptr_q[AW-1:0]] <= mac_data_i;
        if (accept) desc_mem[dwp_q[DW-1:0]] <= '{dmac: dmac_n, start: start[AW-1:0], len: new_len};
        ram_q <= mem[raddr];
    end

    always_comb begin
        head       = desc_mem[drp_q[DW-1:0]];
        desc_empty = (dwp_q == drp_q);
        raddr      = head.start + cnt_q[AW-1:0];
        state_d    = state_q;
        dest_d     = dest_q;
        cnt_d      = '0;
        lkp_req_d  = lkp_req_q;
        lkp_mac_d  = lkp_mac_q;
        rv1_d      = 1'b0;
        last1_d    = 1'b0;
        pop        = 1'b0;
        disc       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!desc_empty) begin
                    state_d   = S_LOOKUP;
                    lkp_req_d = 1'b1;
                    lkp_mac_d = head.dmac;
                end
            end
            S_LOOKUP: begin
                if (lkp_ack_i) begin
                    lkp_req_d = 1'b0;
                    if (lkp_port_i == 3'(P_PORT) || lkp_port_i > 3'd4) begin
                        state_d = S_DISCARD;
                    end else begin
                        state_d = S_STREAM;
                        dest_d  = lkp_port_i;
                    end
                end else if (tmo_exp) begin
                    lkp_req_d = 1'b0;
                    state_d   = S_STREAM;
                    dest_d    = 3'd4;
                end
            end
            S_STREAM: begin
                rv1_d   = 1'b1;
                last1_d = (cnt_q == head.len - (AW+1)'(1));
                cnt_d   = cnt_q + (AW+1)'(1);
                if (last1_d) begin
                    pop     = 1'b1;
                    state_d = S_GAP;
                end
            end
            S_DISCARD: begin
                pop     = 1'b1;
                disc    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        rd_ptr_d  = pop ? rd_ptr_q + head.len : rd_ptr_q;
        drp_d     = drp_q + (DW+1)'(pop);
        rx_data_d = rv1_q ? ram_q : 8'h00;
        rx_done_d = rv1_q && last1_q;
        rx_dest_d = rv1_q ? dest_q : 3'h7;
        drop_sum  = {1'b0, drop_q} + 17'(reject) + 17'(disc);
        drop_d    = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            len_q       <= '0;
            frm_start_q <= '0;
            in_frm_q    <= 1'b0;
            ovf_q       <= 1'b0;
            dmac_q      <= '0;
            dwp_q       <= '0;
            drp_q       <= '0;
            state_q     <= S_IDLE;
            dest_q      <= 3'h7;
            cnt_q       <= '0;
            lkp_req_q   <= 1'b0;
            lkp_mac_q   <= '0;
            rv1_q       <= 1'b0;
            last1_q     <= 1'b0;
            rx_data_q   <= '0;
            rx_done_q   <= 1'b0;
            rx_dest_q   <= 3'h7;
            drop_q      <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            len_q       <= len_d;
            frm_start_q <= frm_start_d;
            in_frm_q    <= in_frm_d;
            ovf_q       <= ovf_d;
            dmac_q      <= dmac_d;
            dwp_q       <= dwp_d;
            drp_q       <= drp_d;
            state_q     <= state_d;
            dest_q      <= dest_d;
            cnt_q       <= cnt_d;
            lkp_req_q   <= lkp_req_d;
            lkp_mac_q   <= lkp_mac_d;
            rv1_q       <= rv1_d;
            last1_q     <= last1_d;
            rx_data_q   <= rx_data_d;
            rx_done_q   <= rx_done_d;
            rx_dest_q   <= rx_dest_d;
            drop_q      <= drop_d;
        end
    end

    assign lkp_req_o  = lkp_req_q;
    assign lkp_mac_o  = lkp_mac_q;
    assign rx_data_o  = rx_data_q;
    assign rx_done_o  = rx_done_q;
    assign rx_dest_o  = rx_dest_q;
    assign drop_cnt_o = drop_q;
endmodule
